hall_decoder: RTL and testbench
===============================

Name: hall_decoder

Overview:
- Reads the three hall-effect sensor lines of one BLDC motor: synchronises, glitch-filters and decodes them into a sector index.
- Accumulates signed commutation steps and measures the step period in clock cycles.
- Presents latched delta/period snapshots to the CPU-facing register block.
- Sits beside the motor driver on the same hall pins. It is the feedback/sensing end of the commutation interface the driver consumes.

Parameters:
- FILTER_CYCLES, 4: consecutive clocks a new synchronised hall code must hold before acceptance (range 1–255).
- COUNT_WIDTH, 16: width of the signed step accumulator and the delta output.
- PERIOD_WIDTH, 20: width of the period counter and the period output.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- hall  in  3  raw hall inputs, asynchronous to clk.
- latch  in  1  single-cycle snapshot request from the CPU side.
- delta  out  COUNT_WIDTH  signed steps accumulated between the last two latches.
- period  out  PERIOD_WIDTH  clocks between the last two counted steps; all-ones when stalled.
- latch_valid  out  1  one-cycle pulse; delta is fresh.
- direction  out  1  1 = forward, last counted step; 0 = reverse.
- sector  out  3  current sector 0–5; 7 = unknown.
- stalled  out  1  period counter saturated.
- fault  out  1  accepted code is 000 or 111.
- skip_count  out  8  saturating count of illegal sector jumps.

Behaviour:
- Reset (rst_n low, async) clears delta, period, latch_valid, direction, stalled, fault, skip_count, the accumulator, the period counter and the filter counter. It sets sector=7 and the accepted code to 000. The synchroniser flops are cleared to 000.
- Synchroniser: 2 flops. hall_s reflects hall after 2 edges.
- Filter:
  - The counter increments on every edge where hall_s ≠ accepted code and hall_s equals the previous hall_s.
  - Any change in hall_s resets the counter to 1.
  - The code is accepted on the edge the counter reaches FILTER_CYCLES. The counter then clears.
  - Total latency from a clean hall change to acceptance is 2+FILTER_CYCLES edges.
- Decode, forward sequence: 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. 000/111 are invalid.
- On acceptance of code c with sector index n, previous sector p:
  - Invalid c: fault=1, sector=7. Accumulator and period are unchanged.
  - Valid c, p=7 (after reset or after a fault): sector=n, fault=0. This is a resync and is not counted.
  - n=(p+1) mod 6: step=+1, direction=1.
  - n=(p+5) mod 6: step=−1, direction=0.
  - Any other jump: skip_count+1 (saturates at 255), sector=n, not counted.
- Counted step: the accumulator adds step, wrapping modulo 2^COUNT_WIDTH. On the same edge: period<=period counter, period counter<=1, stalled<=0.
- Period counter:
  - Increments every edge otherwise and saturates at all-ones.
  - When saturated, stalled=1 and period reads all-ones.
  - The first counted step after reset or stall loads all-ones into period.
- Latch:
  - On an edge with latch=1: delta<=accumulator (excluding any step counted on that same edge), and accumulator<=that step (0 or ±1).
  - latch_valid is high for exactly the following cycle.
  - Back-to-back latches are legal; each produces its own pulse.
- Reset mid-filter or mid-latch discards all state. There is no latch_valid pulse after reset.

Test Plan:
- Reset, then hall=101 held 10 clks → sector=0 after edge 6 (FILTER_CYCLES=4). delta=0 on a latch. skip_count=0.
- Forward sequence 101,100,110,010,011,001,101, each held 100 clks, then latch → delta=+6, direction=1, period=100, latch_valid one cycle.
- Same sequence reversed, then latch → delta=−6, direction=0. Accumulator wraps: 32768 forward steps from 0 with COUNT_WIDTH=16 → delta=−32768.
- 2-clk glitch 101→100→101 → no acceptance, sector stays 0, delta 0. Jump 101→110 → skip_count=1, sector=2, no step.
- Hall=000 for 10 clks → fault=1, sector=7. Then 100 → resync sector=1 with no step counted, fault=0.
- No transitions for 2^20 clks → stalled=1, period=0xFFFFF. Latch asserted on the same edge as a +1 step → delta excludes it, and the next latch shows +1.

Source files
------------

// File: rtl/hall_decoder_if.sv
// CPU-facing register interface of the hall decoder: snapshot request plus
// the latched measurement and status fields it returns.
interface hall_decoder_if #(
  parameter int COUNT_WIDTH  = 16,
  parameter int PERIOD_WIDTH = 20
);
  logic                    latch;
  logic [COUNT_WIDTH-1:0]  delta;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    latch_valid;
  logic                    direction;
  logic [2:0]              sector;
  logic                    stalled;
  logic                    fault;
  logic [7:0]              skip_count;

  modport master (
    output latch,
    input  delta, period, latch_valid, direction, sector, stalled, fault, skip_count
  );

  modport slave (
    input  latch,
    output delta, period, latch_valid, direction, sector, stalled, fault, skip_count
  );
endinterface

// File: rtl/hall_decoder.sv
// BLDC hall sensor front end: synchronise, glitch-filter, decode to a sector,
// accumulate signed commutation steps and measure the step period.
module hall_decoder #(
  parameter int FILTER_CYCLES = 4,
  parameter int COUNT_WIDTH   = 16,
  parameter int PERIOD_WIDTH  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall,
  hall_decoder_if.slave bus
);

  localparam logic [7:0]              FILT   = 8'(FILTER_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] P_ONES = '1;
  localparam logic [2:0]              SEC_UNKNOWN = 3'd7;

  logic [2:0]              sync1, hall_s, prev_s, code;
  logic [7:0]              filt_cnt, filt_next;
  logic                    accept;
  logic [2:0]              sector_q, n_sec;
  logic                    step_up, step_dn, skip;
  logic [COUNT_WIDTH-1:0]  accum, step_val, delta_q;
  logic [PERIOD_WIDTH-1:0] pcnt, period_q;
  logic                    have_ref;
  logic                    latch_valid_q, direction_q, stalled_q, fault_q;
  logic [7:0]              skip_q;

  function automatic logic [2:0] decode(input logic [2:0] c);
    case (c)
      3'b101:  decode = 3'd0;
      3'b100:  decode = 3'd1;
      3'b110:  decode = 3'd2;
      3'b010:  decode = 3'd3;
      3'b011:  decode = 3'd4;
      3'b001:  decode = 3'd5;
      default: decode = SEC_UNKNOWN;
    endcase
  endfunction

  function automatic logic [2:0] inc6(input logic [2:0] s);
    inc6 = (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  // A return to the accepted code cancels any pending candidate outright.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    filt_next = filt_cnt;
    accept    = 1'b0;
    if (hall_s == code) begin
      filt_next = 8'd0;
    end else begin
      filt_next = (hall_s != prev_s) ? 8'd1 : filt_cnt + 8'd1;
      if (filt_next == FILT) begin
        accept    = 1'b1;
        filt_next = 8'd0;
      end
    end
  end

  always_comb begin
    n_sec   = decode(hall_s);
    step_up = 1'b0;
    step_dn = 1'b0;
    skip    = 1'b0;
    if (accept && n_sec != SEC_UNKNOWN && sector_q != SEC_UNKNOWN) begin
      if (n_sec == inc6(sector_q))      step_up = 1'b1;
      else if (sector_q == inc6(n_sec)) step_dn = 1'b1;
      else                              skip    = 1'b1;
    end
    step_val = step_up ? COUNT_WIDTH'(1) : (step_dn ? '1 : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1         <= 3'b000;
      hall_s        <= 3'b000;
      prev_s        <= 3'b000;
      code          <= 3'b000;
      filt_cnt      <= 8'd0;
      sector_q      <= SEC_UNKNOWN;
      fault_q       <= 1'b0;
      skip_q        <= 8'd0;
      direction_q   <= 1'b0;
      accum         <= '0;
      delta_q       <= '0;
      latch_valid_q <= 1'b0;
      pcnt          <= '0;
      period_q      <= '0;
      stalled_q     <= 1'b0;
      have_ref      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      sync1    <= hall;
      hall_s   <= sync1;
      prev_s   <= hall_s;
      filt_cnt <= filt_next;

      if (accept) begin
        code     <= hall_s;
        sector_q <= n_sec;
        fault_q  <= (n_sec == SEC_UNKNOWN);
      end
      if (skip && skip_q != 8'hFF) skip_q <= skip_q + 8'd1;
      if (step_up)      direction_q <= 1'b1;
      else if (step_dn) direction_q <= 1'b0;

      // A step counted on the latch edge belongs to the next snapshot.
      if (bus.latch) begin
        delta_q <= accum;
        accum   <= step_val;
      end else begin
        accum   <= accum + step_val;
      end
      latch_valid_q <= bus.latch;

      // Without a previous step (reset) or after a stall there is no valid
      // reference edge, so the period reads as all-ones.
      if (step_up || step_dn) begin
        period_q  <= have_ref ? pcnt : P_ONES;
        pcnt      <= PERIOD_WIDTH'(1);
        stalled_q <= 1'b0;
        have_ref  <= 1'b1;
      end else if (pcnt == P_ONES) begin
        stalled_q <= 1'b1;
        period_q  <= P_ONES;
      end else begin
        pcnt <= pcnt + PERIOD_WIDTH'(1);
      end
    end
  end

  assign bus.delta       = delta_q;
  assign bus.period      = period_q;
  assign bus.latch_valid = latch_valid_q;
  assign bus.direction   = direction_q;
  assign bus.sector      = sector_q;
  assign bus.stalled     = stalled_q;
  assign bus.fault       = fault_q;
  assign bus.skip_count  = skip_q;

endmodule

// File: tb/tb_hall_decoder.sv
// Directed self-checking bench for hall_decoder, using narrow counters so the
// wrap and stall corners are reachable in a short run.
module tb_hall_decoder;
  localparam int CW = 8;
  localparam int PW = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] hall;
  int         errors = 0;
  int         checks = 0;

  hall_decoder_if #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) bus ();

  hall_decoder #(.FILTER_CYCLES(4), .COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hall  (hall),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_latch(input string tag, input logic [31:0] exp_delta);
    bus.latch = 1'b1;
    step(1);
    bus.latch = 1'b0;
    check({tag, "_delta"}, 32'(bus.delta), exp_delta);
    check({tag, "_valid_hi"}, 32'(bus.latch_valid), 32'd1);
    step(1);
    check({tag, "_valid_lo"}, 32'(bus.latch_valid), 32'd0);
  endtask

  logic [2:0] fwd [6];

  initial begin
    fwd = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    rst_n     = 1'b0;
    hall      = 3'b000;
    bus.latch = 1'b0;
    #12;
    check("rst_sector", 32'(bus.sector), 32'd7);
    check("rst_delta", 32'(bus.delta), 32'd0);
    check("rst_period", 32'(bus.period), 32'd0);
    check("rst_valid", 32'(bus.latch_valid), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_stalled", 32'(bus.stalled), 32'd0);
    check("rst_skip", 32'(bus.skip_count), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Resync to sector 0: acceptance lands exactly on the 6th edge.
    hall = 3'b101;
    step(5);
    check("acc_edge5", 32'(bus.sector), 32'd7);
    step(1);
    check("acc_edge6", 32'(bus.sector), 32'd0);
    step(4);
    check("resync_skip", 32'(bus.skip_count), 32'd0);
    do_latch("resync", 32'd0);

    // Six forward steps, 100 clocks apart.
    for (int k = 1; k <= 6; k++) begin
      hall = fwd[k % 6];
      step(100);
    end
    check("fwd_dir", 32'(bus.direction), 32'd1);
    check("fwd_period", 32'(bus.period), 32'd100);
    check("fwd_sector", 32'(bus.sector), 32'd0);
    do_latch("fwd", 32'h06);

    // Six reverse steps back to sector 0.
    for (int k = 5; k >= 0; k--) begin
      hall = fwd[k];
      step(100);
    end
    check("rev_dir", 32'(bus.direction), 32'd0);
    check("rev_period", 32'(bus.period), 32'd100);
    do_latch("rev", 32'hFA);

    // 128 forward steps wrap an 8-bit accumulator to -128.
    for (int k = 1; k <= 128; k++) begin
      hall = fwd[k % 6];
      step(8);
    end
    check("wrap_sector", 32'(bus.sector), 32'd2);
    check("wrap_period", 32'(bus.period), 32'd8);
    do_latch("wrap", 32'h80);

    // Back to sector 0 with two reverse steps.
    hall = 3'b100;
    step(10);
    hall = 3'b101;
    step(10);
    check("back_sector", 32'(bus.sector), 32'd0);
    do_latch("back", 32'hFE);

    // Two-clock glitch must not be accepted.
    hall = 3'b100;
    step(2);
    hall = 3'b101;
    step(10);
    check("glitch_sector", 32'(bus.sector), 32'd0);
    do_latch("glitch", 32'd0);

    // Illegal jump 0 -> 2: counted as a skip, not a step.
    hall = 3'b110;
    step(10);
    check("skip_sector", 32'(bus.sector), 32'd2);
    check("skip_count", 32'(bus.skip_count), 32'd1);
    check("skip_dir", 32'(bus.direction), 32'd0);
    do_latch("skip", 32'd0);

    // Invalid code faults; the next valid code resyncs without a step.
    hall = 3'b000;
    step(10);
    check("fault_flag", 32'(bus.fault), 32'd1);
    check("fault_sector", 32'(bus.sector), 32'd7);
    hall = 3'b100;
    step(10);
    check("resync_sector", 32'(bus.sector), 32'd1);
    check("resync_fault", 32'(bus.fault), 32'd0);
    check("resync_skip2", 32'(bus.skip_count), 32'd1);
    do_latch("fault", 32'd0);

    // Stall: period counter saturates.
    step(1100);
    check("stall_flag", 32'(bus.stalled), 32'd1);
    check("stall_period", 32'(bus.period), 32'h3FF);

    // Latch on the same edge as a +1 step: the step goes to the next snapshot.
    hall = 3'b110;
    step(5);
    check("pre_step_sector", 32'(bus.sector), 32'd1);
    bus.latch = 1'b1;
    step(1);
    bus.latch = 1'b0;
    check("same_edge_sector", 32'(bus.sector), 32'd2);
    check("same_edge_delta", 32'(bus.delta), 32'd0);
    check("same_edge_valid", 32'(bus.latch_valid), 32'd1);
    check("post_stall_flag", 32'(bus.stalled), 32'd0);
    check("post_stall_period", 32'(bus.period), 32'h3FF);
    check("post_stall_dir", 32'(bus.direction), 32'd1);

    // Back-to-back latches: each gives its own pulse.
    bus.latch = 1'b1;
    step(1);
    check("b2b1_delta", 32'(bus.delta), 32'd1);
    check("b2b1_valid", 32'(bus.latch_valid), 32'd1);
    step(1);
    bus.latch = 1'b0;
    check("b2b2_delta", 32'(bus.delta), 32'd0);
    check("b2b2_valid", 32'(bus.latch_valid), 32'd1);
    step(1);
    check("b2b_valid_lo", 32'(bus.latch_valid), 32'd0);

    // Reset in the middle of a filter window and a latch request.
    hall = 3'b010;
    step(3);
    bus.latch = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    bus.latch = 1'b0;
    check("midrst_sector", 32'(bus.sector), 32'd7);
    check("midrst_skip", 32'(bus.skip_count), 32'd0);
    check("midrst_valid", 32'(bus.latch_valid), 32'd0);
    check("midrst_dir", 32'(bus.direction), 32'd0);
    rst_n = 1'b1;
    step(1);
    check("postrst_valid", 32'(bus.latch_valid), 32'd0);
    step(9);
    check("postrst_sector", 32'(bus.sector), 32'd3);
    check("postrst_delta", 32'(bus.delta), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
